instr_fetch_unit: RTL

Instruction fetch initiator for the byte-addressed, synchronous instruction ROM. Generates word addresses, absorbs the ROM's one-cycle registered read latency with a 2-entry buffer, and delivers {pc, instruction} pairs to decode over a valid/ready handshake. Handles taken-branch redirects from execute by discarding stale fetches, and optionally halts on a sentinel instruction.

---
 rtl/ifu_pkg.sv | 18 +
 rtl/instr_fetch_unit_if.sv | 23 ++
 rtl/ifu_fetch_buffer.sv | 42 ++++
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: FSM states, buffer entry, defaults.
package ifu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } ifu_state_t;

   localparam int          IFU_BUF_DEPTH = 2;
   localparam logic [31:0] IFU_RESET_PC  = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifu_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ROM, decode and redirect signals of the fetch unit; master = fetch unit side.
interface ifu_if;
   logic [31:0] imem_addr;
   logic        imem_rd;
   logic [31:0] imem_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halted;

   modport master (
      output imem_addr, imem_rd, if_valid, if_instr, if_pc, halted,
      input  imem_data, if_ready, redirect, redirect_pc
   );

   modport slave (
      input  imem_addr, imem_rd, if_valid, if_instr, if_pc, halted,
      output imem_data, if_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/ifu_fetch_buffer.sv
// Two-entry {pc, instr} FIFO with synchronous flush; head readable combinationally.
// Push into a full buffer is prevented by the caller's issue throttling.
module ifu_fetch_buffer
   import ifu_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       i_push,
   input  ifu_entry_t i_push_dat,
   input  logic       i_pop,
   input  logic       i_flush,
   output ifu_entry_t o_head_dat,
   output logic [1:0] o_count
);

   ifu_entry_t r_mem [IFU_BUF_DEPTH];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;

   // Flush beats a same-cycle push so a stale response never survives a redirect.
   always_ff @(posedge clock) begin
      if (reset || i_flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (i_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   assign o_head_dat = r_mem[r_rd_ptr];
   assign o_count    = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch initiator: issues word fetches, buffers 2 ROM responses, 2-cycle issue-to-decode, epoch-tagged redirects.
// Optional halt on HALT_WORD when IFU_HALT_EN is defined.
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic clock,
   input  logic reset,
   ifu_if.master io_bus
);

   ifu_state_t  r_state;
   ifu_state_t  w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_addr;
   logic        r_epoch;
   logic        r_inflight;
   logic        r_inflight_tag;
   logic [31:0] r_last_instr;
   logic [31:0] r_last_pc;

   logic        w_valid;
   logic        w_pop;
   logic        w_push;
   logic        w_flush;
   logic        w_issue;
   logic        w_halt_pop;
   logic [1:0]  w_count;
   ifu_entry_t  w_head;
   ifu_entry_t  w_push_dat;

`ifdef IFU_HALT_EN
   assign w_halt_pop     = (r_state == RUN) && w_pop && (w_head.instr == HALT_WORD);
   assign io_bus.halted  = (r_state == HALTED);
`else
   logic w_unused_halt_word;
   assign w_unused_halt_word = ^HALT_WORD;
   assign w_halt_pop         = 1'b0;
   assign io_bus.halted      = 1'b0;
`endif

   assign w_valid = (w_count != 2'd0);
   assign w_pop   = w_valid && io_bus.if_ready;
   assign w_flush = io_bus.redirect || w_halt_pop;
   assign w_push  = r_inflight && (r_inflight_tag == r_epoch);

   // Issue only while buffer + in-flight after this cycle's pop stays within 2.
   assign w_issue = !reset && (r_state == RUN) && !io_bus.redirect && !w_halt_pop &&
                    (({1'b0, w_count} + {2'b00, r_inflight}) <= (3'd1 + {2'b00, w_pop}));

   assign w_push_dat.pc    = r_addr;
   assign w_push_dat.instr = io_bus.imem_data;

   ifu_fetch_buffer u_buf (
      .clock      (clock),
      .reset      (reset),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .i_flush    (w_flush),
      .o_head_dat (w_head),
      .o_count    (w_count)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = RUN;
         RUN:     if (w_halt_pop && !io_bus.redirect) w_state_nxt = HALTED;
         HALTED:  if (io_bus.redirect) w_state_nxt = RUN;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= IDLE;
         r_pc           <= RESET_PC;
         r_addr         <= RESET_PC;
         r_epoch        <= 1'b0;
         r_inflight     <= 1'b0;
         r_inflight_tag <= 1'b0;
         r_last_instr   <= 32'h0;
         r_last_pc      <= 32'h0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_issue;
         if (w_issue) begin
            r_pc           <= r_pc + 32'd4;
            r_addr         <= r_pc;
            r_inflight_tag <= r_epoch;
         end
         if (io_bus.redirect) begin
            r_pc <= io_bus.redirect_pc & 32'hFFFF_FFFC;
         end
         if (w_flush) begin
            r_epoch <= ~r_epoch;
         end
         if (w_valid) begin
            r_last_instr <= w_head.instr;
            r_last_pc    <= w_head.pc;
         end
      end
   end

   // r_addr doubles as the PC of the response returning next cycle.
   assign io_bus.imem_rd   = w_issue;
   assign io_bus.imem_addr = w_issue ? r_pc : r_addr;
   assign io_bus.if_valid  = w_valid;
   assign io_bus.if_instr  = w_valid ? w_head.instr : r_last_instr;
   assign io_bus.if_pc     = w_valid ? w_head.pc : r_last_pc;

endmodule
